// File: rtl/min_receive_fsm.sv
// MIN frame receiver: finds the AA AA AA header, strips stuff bytes, checks
// the length, CRC-32 and EOF, then presents the ID and payload with a valid pulse.
module min_receive_fsm #(
    parameter int N_DATA_BYTE = 4
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_wr,
    input  logic [7:0]               i_data,
    output logic                     o_valid,
    output logic [7:0]               o_id,
    output logic [7:0]               o_len,
    output logic [8*N_DATA_BYTE-1:0] o_data,
    output logic                     o_err,
    output logic [1:0]               o_err_code,
    output logic                     o_busy
);

    typedef enum logic [3:0] {
        S_IDLE, S_ID, S_LEN, S_PAYLOAD,
        S_CRC0, S_CRC1, S_CRC2, S_CRC3, S_EOF
    } state_t;

    localparam logic [7:0] LEN_MAX = 8'(N_DATA_BYTE);

    state_t      state;
    logic [1:0]  aa_cnt;
    logic [31:0] crc;
    logic [31:0] rx_crc;
    logic [7:0]  idx;
    logic [7:0]  id_sh;
    logic [7:0]  len_sh;
    logic [N_DATA_BYTE-1:0][7:0] buf_sh;

    logic [31:0] crc_nxt;
    logic        hdr_hit;
    logic        stuff_hit;

    // Reflected CRC-32, one byte per cycle (eight bit steps unrolled).
    function automatic logic [31:0] crc_step(input logic [31:0] c, input logic [7:0] b);
        logic [31:0] r;
        r = c ^ {24'h0, b};
        for (int k = 0; k < 8; k++)
            r = r[0] ? ((r >> 1) ^ 32'hEDB8_8320) : (r >> 1);
        return r;
    endfunction

    assign crc_nxt   = crc_step(crc, i_data);
    assign hdr_hit   = (i_data == 8'hAA) && (aa_cnt == 2'd2);
    assign stuff_hit = (state != S_IDLE) && (state != S_EOF) &&
                       (aa_cnt == 2'd2) && (i_data == 8'h55);
    assign o_busy    = (state != S_IDLE);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state      <= S_IDLE;
            aa_cnt     <= 2'd0;
            crc        <= 32'hFFFF_FFFF;
            rx_crc     <= 32'h0;
            idx        <= 8'h0;
            id_sh      <= 8'h0;
            len_sh     <= 8'h0;
            buf_sh     <= '0;
            o_valid    <= 1'b0;
            o_id       <= 8'h0;
            o_len      <= 8'h0;
            o_data     <= '0;
            o_err      <= 1'b0;
            o_err_code <= 2'd0;
        end else begin
            o_valid <= 1'b0;
            o_err   <= 1'b0;
            if (i_wr) begin
                if (hdr_hit) begin
                    // A header always restarts framing, silently dropping any frame in flight.
                    state  <= S_ID;
                    crc    <= 32'hFFFF_FFFF;
                    idx    <= 8'h0;
                    aa_cnt <= 2'd0;
                end else if (stuff_hit) begin
                    aa_cnt <= 2'd0;
                end else begin
                    aa_cnt <= (i_data == 8'hAA) ? aa_cnt + 2'd1 : 2'd0;
                    case (state)
                        S_IDLE: ;
                        S_ID: begin
                            id_sh <= i_data;
                            crc   <= crc_nxt;
                            state <= S_LEN;
                        end
                        S_LEN: begin
                            len_sh <= i_data;
                            crc    <= crc_nxt;
                            if (i_data > LEN_MAX) begin
                                o_err      <= 1'b1;
                                o_err_code <= 2'd1;
                                state      <= S_IDLE;
                            end else if (i_data == 8'h0) begin
                                state <= S_CRC0;
                            end else begin
                                state <= S_PAYLOAD;
                            end
                        end
                        S_PAYLOAD: begin
                            for (int k = 0; k < N_DATA_BYTE; k++)
                                if (idx == 8'(k)) buf_sh[k] <= i_data;
                            crc <= crc_nxt;
                            idx <= idx + 8'd1;
                            if (idx == len_sh - 8'd1) state <= S_CRC0;
                        end
                        S_CRC0: begin rx_crc <= {rx_crc[23:0], i_data}; state <= S_CRC1; end
                        S_CRC1: begin rx_crc <= {rx_crc[23:0], i_data}; state <= S_CRC2; end
                        S_CRC2: begin rx_crc <= {rx_crc[23:0], i_data}; state <= S_CRC3; end
                        S_CRC3: begin rx_crc <= {rx_crc[23:0], i_data}; state <= S_EOF;  end
                        S_EOF: begin
                            if (i_data == 8'h55 && rx_crc == ~crc) begin
                                o_valid <= 1'b1;
                                o_id    <= id_sh;
                                o_len   <= len_sh;
                                // Stale bytes beyond the length come from older frames; mask them.
                                for (int k = 0; k < N_DATA_BYTE; k++)
                                    o_data[8*(N_DATA_BYTE-1-k) +: 8] <=
                                        (8'(k) < len_sh) ? buf_sh[k] : 8'h0;
                            end else begin
                                o_err      <= 1'b1;
                                o_err_code <= (i_data == 8'h55) ? 2'd2 : 2'd3;
                            end
                            state <= S_IDLE;
                        end
                        default: state <= S_IDLE;
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_min_receive_fsm.sv
// Directed bench for min_receive_fsm: table of frames plus hand-written
// sequences for oversize length, mid-frame header and reset mid-payload.
module tb_min_receive_fsm;

    localparam int N = 4;

    logic           i_clk = 1'b0;
    logic           i_rst;
    logic           i_wr;
    logic [7:0]     i_data;
    logic           o_valid;
    logic [7:0]     o_id;
    logic [7:0]     o_len;
    logic [8*N-1:0] o_data;
    logic           o_err;
    logic [1:0]     o_err_code;
    logic           o_busy;

    int n_chk = 0;
    int n_fail = 0;
    int n_vpulse = 0;
    int n_epulse = 0;
    int n_both = 0;

    min_receive_fsm #(.N_DATA_BYTE(N)) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_wr(i_wr), .i_data(i_data),
        .o_valid(o_valid), .o_id(o_id), .o_len(o_len), .o_data(o_data),
        .o_err(o_err), .o_err_code(o_err_code), .o_busy(o_busy)
    );

    always #5 i_clk = ~i_clk;

    always @(negedge i_clk) begin
        if (o_valid) n_vpulse++;
        if (o_err) n_epulse++;
        if (o_valid && o_err) n_both++;
    end

    typedef struct {
        logic [7:0]  id;
        logic [7:0]  len;
        logic [31:0] pl;       // payload byte 0 in the MSBs
        bit          nostuff;
        bit          corrupt;
        bit          tail_en;
        logic [7:0]  tail;
        bit          ev;       // expected o_valid pulse
        logic [1:0]  ecode;    // expected error code, 0 = none
        logic [7:0]  eid;
        logic [7:0]  elen;
        logic [31:0] edata;
    } vec_t;

    function automatic logic [31:0] crc_upd(input logic [31:0] c, input logic [7:0] b);
        logic [31:0] r;
        r = c ^ {24'h0, b};
        for (int k = 0; k < 8; k++)
            r = r[0] ? ((r >> 1) ^ 32'hEDB8_8320) : (r >> 1);
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        i_wr = 1'b1;
        i_data = b;
        @(posedge i_clk);
        #1;
        i_wr = 1'b0;
    endtask

    // Idle gap with an AA on the bus: must be ignored without i_wr.
    task automatic gap();
        i_data = 8'hAA;
        @(posedge i_clk);
        #1;
    endtask

    task automatic send_raw(input logic [7:0] q[$]);
        for (int i = 0; i < q.size(); i++) begin
            send_byte(q[i]);
            if (i != q.size() - 1) gap();
        end
    endtask

    task automatic run_frame(input string name, input vec_t v);
        logic [7:0]  body[$];
        logic [7:0]  raw[$];
        logic [31:0] c;
        int          cnt;
        int          v0;
        int          e0;
        c = 32'hFFFF_FFFF;
        body.push_back(v.id);
        body.push_back(v.len);
        for (int k = 0; k < int'(v.len); k++) body.push_back(v.pl[31-8*k -: 8]);
        foreach (body[i]) c = crc_upd(c, body[i]);
        c = ~c;
        if (v.corrupt) c[7:0] = c[7:0] ^ 8'h01;
        body.push_back(c[31:24]);
        body.push_back(c[23:16]);
        body.push_back(c[15:8]);
        body.push_back(c[7:0]);
        raw = '{8'hAA, 8'hAA, 8'hAA};
        cnt = 0;
        foreach (body[i]) begin
            raw.push_back(body[i]);
            cnt = (body[i] == 8'hAA) ? cnt + 1 : 0;
            if (cnt == 2 && !v.nostuff) begin
                raw.push_back(8'h55);
                cnt = 0;
            end
        end
        raw.push_back(8'h55);
        if (v.tail_en) raw.push_back(v.tail);
        v0 = n_vpulse;
        e0 = n_epulse;
        send_raw(raw);
        chk({name, " valid"}, 32'(o_valid), 32'(v.ev));
        chk({name, " err"}, 32'(o_err), 32'(v.ecode != 2'd0));
        if (v.ecode != 2'd0) chk({name, " err_code"}, 32'(o_err_code), 32'(v.ecode));
        chk({name, " id"}, 32'(o_id), 32'(v.eid));
        chk({name, " len"}, 32'(o_len), 32'(v.elen));
        chk({name, " data"}, o_data, v.edata);
        repeat (2) @(posedge i_clk);
        #1;
        chk({name, " valid pulses"}, 32'(n_vpulse - v0), 32'(v.ev));
        chk({name, " err pulses"}, 32'(n_epulse - e0), 32'(v.ecode != 2'd0));
        chk({name, " busy after"}, 32'(o_busy), 32'd0);
    endtask

    vec_t tbl[6];
    vec_t hv;
    int   e_mark;
    int   v_mark;

    initial begin
        tbl[0] = '{8'h01, 8'd4, 32'h12345678, 0, 0, 0, 8'h00, 1, 2'd0, 8'h01, 8'd4, 32'h12345678};
        tbl[1] = '{8'h03, 8'd4, 32'hAAAA0001, 0, 0, 0, 8'h00, 1, 2'd0, 8'h03, 8'd4, 32'hAAAA0001};
        // 55 following AA AA is taken as stuffing, so the frame shifts by one byte
        // and the trailing 00 lands in the EOF slot.
        tbl[2] = '{8'h04, 8'd4, 32'hAAAA5501, 1, 0, 1, 8'h00, 0, 2'd3, 8'h03, 8'd4, 32'hAAAA0001};
        tbl[3] = '{8'h05, 8'd2, 32'hDEAD0000, 0, 1, 0, 8'h00, 0, 2'd2, 8'h03, 8'd4, 32'hAAAA0001};
        tbl[4] = '{8'h06, 8'd2, 32'hDEAD0000, 0, 0, 0, 8'h00, 1, 2'd0, 8'h06, 8'd2, 32'hDEAD0000};
        tbl[5] = '{8'h07, 8'd0, 32'h00000000, 0, 0, 0, 8'h00, 1, 2'd0, 8'h07, 8'd0, 32'h00000000};

        i_rst = 1'b1;
        i_wr = 1'b0;
        i_data = 8'h00;
        repeat (3) @(posedge i_clk);
        #1;
        chk("reset valid", 32'(o_valid), 32'd0);
        chk("reset err", 32'(o_err), 32'd0);
        chk("reset code", 32'(o_err_code), 32'd0);
        chk("reset id", 32'(o_id), 32'd0);
        chk("reset len", 32'(o_len), 32'd0);
        chk("reset data", o_data, 32'd0);
        chk("reset busy", 32'(o_busy), 32'd0);
        @(negedge i_clk);
        i_rst = 1'b0;
        @(posedge i_clk);
        #1;

        for (int r = 0; r < 6; r++) run_frame($sformatf("row%0d", r), tbl[r]);

        // Oversize length: error right after the LEN byte, outputs untouched.
        e_mark = n_epulse;
        send_raw('{8'hAA, 8'hAA, 8'hAA, 8'h01, 8'h05});
        chk("len5 err", 32'(o_err), 32'd1);
        chk("len5 code", 32'(o_err_code), 32'd1);
        chk("len5 valid", 32'(o_valid), 32'd0);
        chk("len5 busy", 32'(o_busy), 32'd0);
        chk("len5 id hold", 32'(o_id), 32'h07);
        repeat (2) @(posedge i_clk);
        #1;
        chk("len5 err pulses", 32'(n_epulse - e_mark), 32'd1);
        hv = '{8'h09, 8'd1, 32'h5A000000, 0, 0, 0, 8'h00, 1, 2'd0, 8'h09, 8'd1, 32'h5A000000};
        run_frame("after len5", hv);

        // Header inside a frame aborts it silently.
        e_mark = n_epulse;
        v_mark = n_vpulse;
        send_raw('{8'hAA, 8'hAA, 8'hAA, 8'h01, 8'h04, 8'h12});
        chk("midhdr busy", 32'(o_busy), 32'd1);
        hv = '{8'h02, 8'd3, 32'h11223300, 0, 0, 0, 8'h00, 1, 2'd0, 8'h02, 8'd3, 32'h11223300};
        run_frame("midhdr", hv);
        chk("midhdr no err", 32'(n_epulse - e_mark), 32'd0);
        chk("midhdr one valid", 32'(n_vpulse - v_mark), 32'd1);

        // Asynchronous reset in the middle of a payload.
        send_raw('{8'hAA, 8'hAA, 8'hAA, 8'h01, 8'h04, 8'h12, 8'h34});
        chk("pre-rst busy", 32'(o_busy), 32'd1);
        #2;
        i_rst = 1'b1;
        #1;
        chk("rst busy", 32'(o_busy), 32'd0);
        chk("rst id", 32'(o_id), 32'd0);
        chk("rst len", 32'(o_len), 32'd0);
        chk("rst data", o_data, 32'd0);
        chk("rst valid", 32'(o_valid), 32'd0);
        @(negedge i_clk);
        i_rst = 1'b0;
        @(posedge i_clk);
        #1;
        hv = '{8'h0A, 8'd4, 32'h01020304, 0, 0, 0, 8'h00, 1, 2'd0, 8'h0A, 8'd4, 32'h01020304};
        run_frame("after rst", hv);

        chk("valid and err together", 32'(n_both), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_fail, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/min_receive_fsm.md
Name: min_receive_fsm

Overview:
- Receive-side MIN frame decoder; the counterpart of the MIN transmit framer.
- Consumes the byte stream from the UART receiver (one byte per strobe) and finds the 0xAA 0xAA 0xAA header.
- Removes stuff bytes, checks length, CRC-32 and EOF, then presents the frame ID and payload with a one-cycle valid pulse.
- Sits between the UART rx output and the host-command register logic, in the sclk domain.

Parameters:
- N_DATA_BYTE, 4, maximum payload bytes accepted and width of o_data in bytes (1..255).

Ports:
- i_clk  input  1  sampling clock (sclk).
- i_rst  input  1  asynchronous active-high reset.
- i_wr  input  1  received-byte strobe; one cycle per byte.
- i_data  input  8  received byte, qualified by i_wr.
- o_valid  output  1  one-cycle pulse: good frame; o_id/o_len/o_data updated the same cycle.
- o_id  output  8  ID/control byte of the last good frame.
- o_len  output  8  payload length of the last good frame.
- o_data  output  8*N_DATA_BYTE  payload; byte 0 in the MSBs, unused low bytes zero.
- o_err  output  1  one-cycle pulse: frame rejected.
- o_err_code  output  2  valid with o_err: 1 = length > N_DATA_BYTE, 2 = CRC mismatch, 3 = bad EOF.
- o_busy  output  1  high while a frame body is being received (states ID..EOF).

Behaviour:
- Reset (asynchronous):
  - Every output is 0, including o_data, o_id and o_len.
  - State IDLE; CRC register = 0xFFFFFFFF; AA counter = 0.
- Byte handling: all state changes occur only on cycles with i_wr=1. Bytes without i_wr are ignored.
- Header detection runs in every state.
  - A 2-bit counter counts consecutive raw 0xAA bytes.
  - The third consecutive 0xAA forces state ID, resets the CRC register to 0xFFFFFFFF and clears the payload index.
  - A frame in progress is aborted silently, with no o_err.
- Stuffing (states ID..CRC3):
  - If the previous two raw bytes were 0xAA and the current byte is 0x55, the byte is dropped: no state advance and no CRC update. The AA counter clears.
  - Any non-0xAA byte clears the AA counter.
- States:
  - IDLE: waits for the header.
  - ID: stores the byte into the shadow ID; CRC update; go to LEN.
  - LEN:
    - Stores the length; CRC update.
    - If length > N_DATA_BYTE: pulse o_err, code 1, go to IDLE.
    - If length = 0: go to CRC0.
    - Otherwise: go to PAYLOAD.
  - PAYLOAD:
    - Writes the byte into the shadow buffer at the index; CRC update; index increments.
    - After byte length-1, go to CRC0.
  - CRC0..CRC3: shift the received bytes into the 32-bit received-CRC register, MSB byte first (big-endian). No CRC update.
  - EOF:
    - Byte 0x55 and received CRC = ~CRC register: pulse o_valid. The same cycle, copy the shadow ID, length and buffer to the outputs, with buffer bytes ≥ length zeroed. Go to IDLE.
    - Byte 0x55 but CRC mismatch: o_err, code 2.
    - Any other byte: o_err, code 3.
    - Both error cases go to IDLE.
- CRC:
  - CRC-32, reflected polynomial 0xEDB88320, init 0xFFFFFFFF, final XOR 0xFFFFFFFF.
  - Covers the unstuffed ID, LEN and payload bytes.
  - Eight bit-serial steps are unrolled combinationally, so one byte is processed per cycle.
- Latency: o_valid and o_err are registered and assert on the cycle after the i_wr carrying the EOF (or offending) byte.
- Outputs hold their values between good frames. Rejected frames never modify o_id, o_len or o_data.
- o_valid and o_err are never high together.
- Back-to-back frames: an i_wr on the cycle right after EOF is processed normally from IDLE.

Test Plan:
- Good frame: AA AA AA 01 04 12 34 56 78 + CRC (from the bench model) + 55.
  - Required: one o_valid pulse one cycle after EOF; o_id=0x01, o_len=4, o_data=0x12345678; o_err never asserted.
- Stuffing: payload AA AA 00 01 with a 55 inserted after the AA AA.
  - Required: o_data=0xAAAA0001 and the CRC passes.
  - A variant with the stuff byte omitted is required to yield o_err code 2 or 3 (per model), with o_data unchanged.
- Corrupt one CRC byte:
  - Required: o_err=1 with code 2, no o_valid; o_data keeps the previous frame's value.
- Length 5 with N_DATA_BYTE=4:
  - Required: o_err code 1 one cycle after the LEN byte.
  - A following valid frame is required to decode correctly.
- Mid-frame header:
  - Stimulus: AA AA AA 01 04 12, then a full valid frame with ID 0x02.
  - Required: no o_err, exactly one o_valid with o_id=0x02.
- Length 0 frame, plus reset asserted mid-payload:
  - Length 0: o_valid with o_data=0 and o_len=0.
  - Mid-payload reset: all outputs 0 immediately and o_busy=0; the next frame decodes.
